// File: rtl/afifo_arb_pkg.sv
// afifo_arb_pkg: shared types and constants for the afifo write-port arbiter.
//   arb_state_e  - arbiter state encoding {IDLE, GRANT}
//   clog2()      - width helper, never returns less than 1 so a single
//                  requester still yields a legal 1-bit id vector
//   DEF_NREQ / DEF_BURST - default requester count and burst length
package afifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_BURST = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/afifo_rr_pick.sv
// afifo_rr_pick: combinational round-robin picker.
//   valid [NREQ]  - request vector
//   ptr   [IDW]   - highest-priority index for this scan
//   found         - at least one request is set
//   idx   [IDW]   - first set index at or above ptr, wrapping modulo NREQ
module afifo_rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic            found,
   output logic [IDW-1:0]  idx
);

   logic [IDW-1:0] cand;

   // NOTE: every always_comb output gets a default before any branch;
   // a path that leaves a variable unassigned infers a latch.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      // Scan from the farthest offset down to offset 0 so the nearest
      // candidate to ptr is the last one written and therefore wins.
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = IDW'((int'(ptr) + i) % NREQ);
         if (valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/afifo_wr_arb.sv
// afifo_wr_arb: round-robin arbiter sharing the afifo write port among
// NREQ valid/ready requesters in the wclk domain, granting bursts of up to
// BURST beats and stalling on fifo_wfull.
//   wclk, wrst            - write clock, async active-high reset
//   req_valid/req_data    - requester handshake in (data flattened, k at [k*DSIZE +: DSIZE])
//   req_ready             - one-hot (or zero) accept back to requesters
//   fifo_wren/fifo_wdata  - afifo write port; fifo_wfull back-pressure in
//   gnt_valid/gnt_id      - current grant (gnt_id is 0 with no grant)
module afifo_wr_arb import afifo_arb_pkg::*; #(
   parameter  int NREQ  = DEF_NREQ,
   parameter  int DSIZE = 8,
   parameter  int BURST = DEF_BURST,
   localparam int IDW   = clog2(NREQ)
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  fifo_wren,
   output logic [DSIZE-1:0]      fifo_wdata,
   input  logic                  fifo_wfull,
   output logic                  gnt_valid,
   output logic [IDW-1:0]        gnt_id
);

   localparam int            CW       = clog2(BURST + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);

   arb_state_e     state_q, state_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

   logic [DSIZE-1:0] data_arr [NREQ];
   logic             cur_valid;
   logic             beat;
   logic             release_now;
   logic [IDW-1:0]   next_ptr;
   logic [IDW-1:0]   pick_ptr;
   logic             pick_found;
   logic [IDW-1:0]   pick_idx;

   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign data_arr[k] = req_data[k*DSIZE +: DSIZE];
   end

   assign cur_valid   = req_valid[gnt_id_q];
   assign beat        = (state_q == GRANT) && cur_valid && !fifo_wfull;
   // Release on the last beat of the burst, or as soon as the owner drops
   // valid -- the latter does not wait for wfull to clear.
   assign release_now = (state_q == GRANT) &&
                        ((beat && (beat_cnt_q == LAST_CNT)) || !cur_valid);
   assign next_ptr    = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;

   // One picker serves both paths: IDLE scans from rr_ptr, a release scans
   // from the slot after the current owner so the owner ends up last.
   assign pick_ptr = (state_q == GRANT) ? next_ptr : rr_ptr_q;

   afifo_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .valid (req_valid),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      gnt_id_d   = gnt_id_q;
      beat_cnt_d = beat_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d    = GRANT;
               gnt_id_d   = pick_idx;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               rr_ptr_d   = next_ptr;
               beat_cnt_d = '0;
               if (pick_found) begin
                  gnt_id_d = pick_idx;
               end else begin
                  state_d  = IDLE;
                  gnt_id_d = '0;
               end
            end else if (beat) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state_q    <= IDLE;
         gnt_id_q   <= '0;
         beat_cnt_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         gnt_id_q   <= gnt_id_d;
         beat_cnt_q <= beat_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   // Outputs are decoded from registers, so an async reset drops them at once.
   always_comb begin
      req_ready  = '0;
      fifo_wdata = '0;
      if (state_q == GRANT) begin
         req_ready[gnt_id_q] = !fifo_wfull;
         fifo_wdata          = data_arr[gnt_id_q];
      end
   end

   assign fifo_wren = beat;
   assign gnt_valid = (state_q == GRANT);
   assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_afifo_wr_arb.sv
// tb_afifo_wr_arb: randomized scoreboard bench for afifo_wr_arb.
// A transaction-level arbiter model predicts each cycle's outputs; the
// driver pushes the prediction, a monitor pops and compares at negedge.
module tb_afifo_wr_arb;

   localparam int NREQ  = 4;
   localparam int DSIZE = 8;
   localparam int BURST = 4;
   localparam int IDW   = 2;

   typedef struct packed {
      logic [NREQ-1:0]  ready;
      logic             wren;
      logic [DSIZE-1:0] wdata;
      logic             gv;
      logic [IDW-1:0]   id;
   } exp_t;

   logic                  wclk;
   logic                  wrst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_wren;
   logic [DSIZE-1:0]      fifo_wdata;
   logic                  fifo_wfull;
   logic                  gnt_valid;
   logic [IDW-1:0]        gnt_id;

   afifo_wr_arb #(
      .NREQ  (NREQ),
      .DSIZE (DSIZE),
      .BURST (BURST)
   ) dut (
      .wclk       (wclk),
      .wrst       (wrst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_wren  (fifo_wren),
      .fifo_wdata (fifo_wdata),
      .fifo_wfull (fifo_wfull),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Requester and model state.
   bit               pres [NREQ];
   logic [DSIZE-1:0] dat  [NREQ];
   int               m_owner;   // -1 when no grant is held
   int               m_used;    // beats written under the current grant
   int               m_ptr;     // first index to scan at the next arbitration
   exp_t             cur_exp;
   exp_t             exp_q [$];

   function automatic int first_from(input int start, input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) begin
         if (v[(start + i) % NREQ]) return (start + i) % NREQ;
      end
      return -1;
   endfunction

   function automatic exp_t model_outputs();
      exp_t e;
      e = '0;
      if (m_owner >= 0) begin
         e.gv    = 1'b1;
         e.id    = IDW'(m_owner);
         e.wdata = dat[m_owner];
         if (!fifo_wfull) e.ready[m_owner] = 1'b1;
         e.wren  = req_valid[m_owner] && !fifo_wfull;
      end
      return e;
   endfunction

   // Advance the model across one clock edge using the inputs held over it.
   task automatic model_advance();
      bit wrote;
      if (m_owner < 0) begin
         m_owner = first_from(m_ptr, req_valid);
         m_used  = 0;
      end else begin
         wrote = req_valid[m_owner] && !fifo_wfull;
         if (wrote) m_used++;
         if ((wrote && m_used == BURST) || !req_valid[m_owner]) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = first_from(m_ptr, req_valid);
            m_used  = 0;
         end
      end
   endtask

   task automatic drive_inputs(input logic [NREQ-1:0] en, input int p_valid,
                               input int p_full, input int p_drop);
      for (int k = 0; k < NREQ; k++) begin
         if (!pres[k]) begin
            if (en[k] && $urandom_range(99) < p_valid) begin
               pres[k] = 1'b1;
               dat[k]  = DSIZE'($urandom);
            end
         end else if ($urandom_range(99) < p_drop) begin
            pres[k] = 1'b0;
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         req_valid[k]                = pres[k];
         req_data[k*DSIZE +: DSIZE]  = dat[k];
      end
      fifo_wfull = ($urandom_range(99) < p_full);
   endtask

   // Settle the edge just passed: advance the model, retire accepted items.
   task automatic settle_edge();
      model_advance();
      for (int k = 0; k < NREQ; k++) begin
         if (pres[k] && cur_exp.ready[k] && req_valid[k]) pres[k] = 1'b0;
      end
   endtask

   task automatic cycle(input logic [NREQ-1:0] en, input int p_valid,
                        input int p_full, input int p_drop);
      @(posedge wclk);
      #1;
      settle_edge();
      drive_inputs(en, p_valid, p_full, p_drop);
      cur_exp = model_outputs();
      exp_q.push_back(cur_exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt_valid"}, gnt_valid, 0);
      check({tag, "_gnt_id"}, gnt_id, 0);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_fifo_wren"}, fifo_wren, 0);
      check({tag, "_fifo_wdata"}, fifo_wdata, 0);
   endtask

   // Mid-cycle async reset; requesters keep presenting their pending items.
   task automatic reset_now();
      @(posedge wclk);
      #1;
      settle_edge();
      #1;
      wrst = 1'b1;
      #1;
      check_all_zero("async_rst");
      m_owner = -1;
      m_used  = 0;
      m_ptr   = 0;
      @(posedge wclk);
      @(posedge wclk);
      #1;
      wrst    = 1'b0;
      cur_exp = '0;
   endtask

   // Monitor: compares every predicted cycle against the DUT at negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge wclk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("req_ready", req_ready, e.ready);
            check("fifo_wren", fifo_wren, e.wren);
            check("fifo_wdata", fifo_wdata, e.wdata);
            check("gnt_valid", gnt_valid, e.gv);
            check("gnt_id", gnt_id, e.id);
            check("ready_onehot", ($countones(req_ready) <= 1), 1);
         end
      end
   end

   initial begin
      bit hit;
      wrst       = 1'b1;
      req_valid  = '0;
      req_data   = '0;
      fifo_wfull = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         pres[k] = 1'b0;
         dat[k]  = '0;
      end
      m_owner = -1;
      m_used  = 0;
      m_ptr   = 0;
      cur_exp = '0;

      #2;
      check_all_zero("reset");
      @(posedge wclk);
      @(posedge wclk);
      #2;
      wrst = 1'b0;

      // Single requester streaming continuously: re-granted with no gap.
      repeat (40) cycle(4'b0001, 100, 0, 0);
      // All requesters continuously valid: 0,1,2,3,... rotation.
      repeat (40) cycle(4'b1111, 100, 0, 0);
      // Sparse random traffic with valid drops.
      repeat (200) cycle(4'b1111, 60, 0, 5);
      // Requester 1 alone, then wfull held for 10 cycles mid-burst.
      repeat (6) cycle(4'b0010, 100, 0, 0);
      repeat (10) cycle(4'b0010, 100, 100, 0);
      repeat (12) cycle(4'b0010, 100, 0, 0);
      // Random traffic and random back-pressure, with withdrawals under wfull.
      repeat (400) cycle(4'b1111, 70, 30, 10);

      // Run until beat 2 of a burst is in flight, then reset asynchronously.
      hit = 1'b0;
      for (int n = 0; n < 100 && !hit; n++) begin
         cycle(4'b1111, 100, 0, 0);
         if (m_owner >= 0 && m_used == 2) hit = 1'b1;
      end
      check("midburst_reached", hit, 1);
      reset_now();
      // Arbitration restarts from pointer 0.
      repeat (40) cycle(4'b1111, 100, 0, 0);
      repeat (300) cycle(4'b1111, 50, 20, 5);

      // Traffic stops: grant must lapse and writes cease.
      repeat (20) cycle(4'b0000, 0, 0, 100);
      @(negedge wclk);
      #1;
      check("idle_gnt_valid", gnt_valid, 0);
      check("idle_fifo_wren", fifo_wren, 0);
      check("idle_req_ready", req_ready, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
